song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 play  input  1  level; 1 = run or continue song, 0 = pause, or return to idle once done.
REQ-005 song_sel  input  2  song number; sampled only when leaving IDLE.
REQ-006 note_done  input  1  level from the note player; high when the current note's duration is reached.
REQ-007 rom_addr  output  7  song ROM address = {song, note_idx[4:0]}.
REQ-008 rom_data  input  12  ROM word; [11:6] = note, [5:0] = duration; valid one cycle after rom_addr (synchronous ROM).
REQ-009 note_to_load  output  6  registered note for the note player.
REQ-010 duration_to_load  output  6  registered duration for the note player.
REQ-011 load_new_note  output  1  one-cycle pulse telling the note player to load.
REQ-012 play_enable  output  1  high only while in PLAY with play=1.
REQ-013 song_done  output  1  high while in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, WAIT_ROM, LOAD, PLAY and DONE, and SHALL use binary encoding.
REQ-015 IDLE: when play=1, latch song_sel into song, set note_idx=0, and go to FETCH; otherwise stay in IDLE.
REQ-016 FETCH: drive rom_addr={song,note_idx}, then go to WAIT_ROM unconditionally.
REQ-017 WAIT_ROM, duration field = 0: this is the end-of-song marker; go to DONE with no load.
REQ-018 WAIT_ROM, duration field nonzero: register note_to_load and duration_to_load, then go to LOAD.
REQ-019 LOAD: assert load_new_note for exactly 1 cycle, then go to PLAY.
REQ-020 PLAY first cycle after LOAD: ignore note_done, because the note player's done flag is stale.
REQ-021 PLAY later cycles, play=1 and note_done=1: if note_idx=31 go to DONE; otherwise increment note_idx and go to FETCH.
REQ-022 PLAY with play=0: hold state, note_idx and registered outputs; play_enable=0; note_done is ignored.
REQ-023 Pause outside PLAY: in FETCH, WAIT_ROM and LOAD, play=0 does not stall the FSM; the pause takes effect on entry to PLAY.
REQ-024 Note value 0 is a rest: it is loaded and timed like any other note.
REQ-025 DONE: song_done=1 and play_enable=0; when play=0, go to IDLE and clear note_idx.
REQ-026 note_idx is 5 bits and never wraps within a song; index 31 finishing forces DONE (REQ-021).
REQ-027 Changes to song_sel outside IDLE have no effect.
REQ-028 Latency from play rising in IDLE to the load_new_note pulse SHALL be 3 cycles: IDLE->FETCH->WAIT_ROM->LOAD.
REQ-029 Latency from accepted note_done to the next load_new_note pulse SHALL be 3 cycles.

Reset
REQ-030 While reset=0, the block SHALL hold state=IDLE, song=0, note_idx=0 and rom_addr=0.
REQ-031 While reset=0, all outputs SHALL be 0: note_to_load, duration_to_load, load_new_note, play_enable and song_done.
REQ-032 Reset asserted mid-song SHALL abort at once with no load pulse.
REQ-033 After reset is released, the block restarts from IDLE and needs play=1 to start.

Verification
REQ-034 Basic start: song_sel=2, ROM[64]={note 10, dur 5}, play 0->1 -> rom_addr=64; load_new_note pulses 3 cycles later with note_to_load=10, duration_to_load=5.
REQ-035 Note advance: note_done=1 in the cycle right after LOAD -> ignored; note_done=1 two cycles later -> rom_addr=65, next load 3 cycles later.
REQ-036 Pause: play=0 for 20 cycles in PLAY with note_done=1 -> no advance, play_enable=0; play=1 -> advance on the next cycle.
REQ-037 End marker: ROM[66] duration=0 -> DONE, song_done=1, no load pulse; play=0 -> IDLE next cycle, song_done=0.
REQ-038 Full song: 32 nonzero entries -> exactly 32 load pulses; after idx 31 finishes -> DONE, rom_addr never exceeds {song,31}.
REQ-039 Async reset: reset=0 in the LOAD cycle -> all outputs 0 with no clock edge; after release with play=1 -> restarts at note_idx 0.

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song stored in a synchronous ROM and hands each note to the note player
module song_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic [1:0]  song_sel,
    input  logic        note_done,
    output logic [6:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic [5:0]  note_to_load,
    output logic [5:0]  duration_to_load,
    output logic        load_new_note,
    output logic        play_enable,
    output logic        song_done
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, LOAD, PLAY, DONE} state_t;
    state_t state, next_state;
    logic [1:0] song;
    logic [4:0] note_idx;
    logic       fresh;
    logic       advance;
    logic       end_mark;
    assign end_mark      = rom_data[5:0] == 6'd0;
    assign advance       = state == PLAY && play && note_done && !fresh;
    assign rom_addr      = {song, note_idx};
    assign load_new_note = state == LOAD;
    assign play_enable   = state == PLAY && play;
    assign song_done     = state == DONE;
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end
    // next-state decode; pauses only bite in PLAY and DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = play ? FETCH : IDLE;
            FETCH:    next_state = WAIT_ROM;
            WAIT_ROM: next_state = end_mark ? DONE : LOAD;
            LOAD:     next_state = PLAY;
            PLAY:     next_state = advance ? (note_idx == 5'd31 ? DONE : FETCH) : PLAY;
            DONE:     next_state = play ? DONE : IDLE;
            default:  next_state = IDLE;
        endcase
    end
    // song/index bookkeeping, note registers, and the stale-done mask for the first PLAY cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            song             <= '0;
            note_idx         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            fresh            <= 1'b0;
        end else begin
            if (state == IDLE && play) begin
                song     <= song_sel;
                note_idx <= '0;
            end
            if (state == DONE && !play) note_idx <= '0;
            if (advance && note_idx != 5'd31) note_idx <= note_idx + 5'd1;
            if (state == WAIT_ROM && !end_mark) begin
                note_to_load     <= rom_data[11:6];
                duration_to_load <= rom_data[5:0];
            end
            fresh <= state == LOAD;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench; expected loads come from reading the song table directly
module tb_song_sequencer;
    logic        clk;
    logic        reset;
    logic        play;
    logic [1:0]  song_sel;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        play_enable;
    logic        song_done;

    song_sequencer dut (
        .clk(clk), .reset(reset), .play(play), .song_sel(song_sel), .note_done(note_done),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
        .duration_to_load(duration_to_load), .load_new_note(load_new_note),
        .play_enable(play_enable), .song_done(song_done)
    );

    typedef struct {
        logic [6:0] addr;
        logic [5:0] note;
        logic [5:0] dur;
    } exp_t;

    logic [11:0] rom [128];
    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          passes = 0;
    int          loads = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROM: data follows the address by one clock
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected load sequence: entries of the song up to the first zero duration, at most 32
    task automatic push_song(input logic [1:0] s, output int n);
        logic [11:0] w;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            w = rom[{s, 5'(i)}];
            if (w[5:0] == 6'd0) break;
            exp_q.push_back('{addr: {s, 5'(i)}, note: w[11:6], dur: w[5:0]});
            n++;
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 128; i++)
            rom[i] = {($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(63, 1)), 6'($urandom_range(63, 1))};
    endtask

    // monitor: every load pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b1 && load_new_note === 1'b1) begin
            loads++;
            check("load expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("load rom_addr", rom_addr, e.addr);
                check("load note", note_to_load, e.note);
                check("load duration", duration_to_load, e.dur);
            end
        end
    end

    initial begin
        int n;
        int l0;
        int c;
        logic [1:0] s;
        reset = 1'b0;
        play = 1'b0;
        song_sel = 2'd0;
        note_done = 1'b0;
        fill_rom();
        #3;
        check("reset rom_addr", rom_addr, 0);
        check("reset note", note_to_load, 0);
        check("reset duration", duration_to_load, 0);
        check("reset load", load_new_note, 0);
        check("reset play_enable", play_enable, 0);
        check("reset song_done", song_done, 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("idle no start", {load_new_note, play_enable, song_done, rom_addr}, 0);

        rom[64] = {6'd10, 6'd5};
        rom[65] = {6'd33, 6'd7};
        rom[66] = {6'd20, 6'd0};
        push_song(2'd2, n);
        song_sel = 2'd2;
        play = 1'b1;
        step();
        check("start rom_addr", rom_addr, 64);
        check("fetch no load", load_new_note, 0);
        song_sel = 2'd1;
        step();
        check("wait_rom no load", load_new_note, 0);
        step();
        check("start latency load", load_new_note, 1);
        note_done = 1'b1;
        step();
        check("play enable", play_enable, 1);
        check("load one cycle", load_new_note, 0);
        step();
        check("stale done ignored", rom_addr, 64);
        check("still playing", play_enable, 1);
        note_done = 1'b0;
        step();
        note_done = 1'b1;
        step();
        check("advance rom_addr", rom_addr, 65);
        note_done = 1'b0;
        step();
        step();
        check("advance latency load", load_new_note, 1);
        play = 1'b0;
        note_done = 1'b1;
        step();
        check("paused play_enable", play_enable, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("pause holds", {play_enable, load_new_note, song_done, rom_addr}, {3'b000, 7'd65});
        end
        play = 1'b1;
        step();
        check("resume advance", rom_addr, 66);
        step();
        step();
        check("end marker done", song_done, 1);
        check("end marker no load", load_new_note, 0);
        check("done play_enable", play_enable, 0);
        note_done = 1'b0;
        step();
        check("done holds with play", song_done, 1);
        play = 1'b0;
        step();
        check("idle after done", song_done, 0);
        check("idle index cleared", rom_addr, 64);
        check("directed queue drained", exp_q.size(), 0);

        for (int r = 0; r < 8; r++) begin
            fill_rom();
            s = 2'($urandom_range(3));
            if (r < 5) rom[{s, 5'($urandom_range(31))}][5:0] = 6'd0;
            if (r == 2) rom[{s, 5'd0}][5:0] = 6'd0;
            rom[{s, 5'd1}][11:6] = 6'd0;
            push_song(s, n);
            l0 = loads;
            song_sel = s;
            play = 1'b1;
            step();
            c = 0;
            while (!song_done && c < 3000) begin
                song_sel = 2'($urandom_range(3));
                note_done = $urandom_range(2) == 0;
                play = $urandom_range(7) != 0;
                step();
                check("song latched", rom_addr[6:5], s);
                c++;
            end
            check("song_done reached", song_done, 1);
            check("load count", loads - l0, n);
            check("song queue drained", exp_q.size(), 0);
            play = 1'b0;
            note_done = 1'b0;
            step();
            check("back to idle", {song_done, play_enable}, 0);
        end

        fill_rom();
        s = 2'($urandom_range(3));
        rom[{s, 5'd0}] = {6'd45, 6'd9};
        song_sel = s;
        play = 1'b1;
        step();
        step();
        step();
        check("abort in load", load_new_note, 1);
        reset = 1'b0;
        #1;
        check("async load", load_new_note, 0);
        check("async note", note_to_load, 0);
        check("async duration", duration_to_load, 0);
        check("async rom_addr", rom_addr, 0);
        check("async play_enable", play_enable, 0);
        check("async song_done", song_done, 0);
        repeat (2) step();
        check("held in reset", {load_new_note, rom_addr}, 0);
        exp_q.push_back('{addr: {s, 5'd0}, note: 6'd45, dur: 6'd9});
        reset = 1'b1;
        step();
        check("restart index 0", rom_addr, {s, 5'd0});
        step();
        step();
        check("restart load", load_new_note, 1);
        step();
        check("restart queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
